bus_arbiter: RTL

Two-requester arbiter and transaction sequencer for the CPU's external bus. The CPU core and a secondary master (DMA/video fetch) both issue single-word bus transactions; this block grants one at a time with round-robin fairness. It drives the shared bus strobe, address, data and write-enable, waits for the slave's data-ready, and returns read data with a one-cycle acknowledge. A watchdog terminates hung transactions with an error flag.

---
 rtl/bus_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter and single-word transaction sequencer
// with a watchdog that force-completes hung transactions with an error flag.
module bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              i_cpu_clk,
    input  logic              i_rst_n,
    input  logic              i_m0_req,
    input  logic              i_m0_we,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    input  logic              i_m1_req,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m0_ack,
    output logic              o_m0_err,
    output logic              o_m1_ack,
    output logic              o_m1_err,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_bus_clk,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_data,
    input  logic [DATA_W-1:0] i_bus_data,
    input  logic              i_bus_data_ready,
    output logic [1:0]        o_grant
);

    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t            state, state_n;
    logic              owner, owner_n;
    logic              last_grant, last_grant_n;
    logic              tx_err, tx_err_n;
    logic [WD_W-1:0]   wd, wd_n;
    logic              bus_clk, bus_clk_n;
    logic              bus_we, bus_we_n;
    logic [ADDR_W-1:0] bus_addr, bus_addr_n;
    logic [DATA_W-1:0] bus_data, bus_data_n;
    logic [DATA_W-1:0] rdata, rdata_n;
    logic [1:0]        ack, ack_n;
    logic [1:0]        err, err_n;
    logic [1:0]        grant, grant_n;
    logic              win;

    // A lone requester wins; on a tie the master that did not go last wins.
    always_comb begin
        if (i_m0_req && i_m1_req) begin
            win = ~last_grant;
        end else begin
            win = !i_m0_req;
        end
    end

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_grant_n = last_grant;
        tx_err_n     = tx_err;
        wd_n         = wd;
        bus_clk_n    = bus_clk;
        bus_we_n     = bus_we;
        bus_addr_n   = bus_addr;
        bus_data_n   = bus_data;
        rdata_n      = rdata;
        grant_n      = grant;
        ack_n        = 2'b00;
        err_n        = 2'b00;
        case (state)
            IDLE: begin
                if (i_m0_req || i_m1_req) begin
                    owner_n    = win;
                    bus_we_n   = win ? i_m1_we    : i_m0_we;
                    bus_addr_n = win ? i_m1_addr  : i_m0_addr;
                    bus_data_n = win ? i_m1_wdata : i_m0_wdata;
                    bus_clk_n  = 1'b1;
                    wd_n       = WD_W'(TIMEOUT);
                    grant_n    = win ? 2'b10 : 2'b01;
                    state_n    = BUS;
                end
            end
            BUS: begin
                // Ready takes priority over an expiring watchdog in the same cycle.
                if (i_bus_data_ready) begin
                    if (!bus_we) begin
                        rdata_n = i_bus_data;
                    end
                    bus_clk_n = 1'b0;
                    tx_err_n  = 1'b0;
                    state_n   = DONE;
                end else if (wd == WD_W'(1)) begin
                    bus_clk_n = 1'b0;
                    rdata_n   = '1;
                    tx_err_n  = 1'b1;
                    state_n   = DONE;
                end else begin
                    wd_n = wd - WD_W'(1);
                end
            end
            DONE: begin
                ack_n        = owner ? 2'b10 : 2'b01;
                err_n        = tx_err ? ack_n : 2'b00;
                last_grant_n = owner;
                grant_n      = 2'b00;
                state_n      = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_cpu_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            tx_err     <= 1'b0;
            wd         <= '0;
            bus_clk    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_data   <= '0;
            rdata      <= '0;
            ack        <= 2'b00;
            err        <= 2'b00;
            grant      <= 2'b00;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_grant <= last_grant_n;
            tx_err     <= tx_err_n;
            wd         <= wd_n;
            bus_clk    <= bus_clk_n;
            bus_we     <= bus_we_n;
            bus_addr   <= bus_addr_n;
            bus_data   <= bus_data_n;
            rdata      <= rdata_n;
            ack        <= ack_n;
            err        <= err_n;
            grant      <= grant_n;
        end
    end

    assign o_m0_ack   = ack[0];
    assign o_m1_ack   = ack[1];
    assign o_m0_err   = err[0];
    assign o_m1_err   = err[1];
    assign o_rdata    = rdata;
    assign o_bus_clk  = bus_clk;
    assign o_bus_we   = bus_we;
    assign o_bus_addr = bus_addr;
    assign o_bus_data = bus_data;
    assign o_grant    = grant;

endmodule
